// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, select encodings and queue entry type for the writeback arbiter
package wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;

  localparam logic WSEL_ALU   = 1'b0;
  localparam logic WSEL_OTHER = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - other-path FIFO with address-match kill and per-entry hazard outputs
module wb_queue import wb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int QDEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       kill_en,
  input  logic [ADDR_W-1:0]          kill_addr,
  output logic                       head_avail,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(QDEPTH):0]    count,
  output logic [QDEPTH-1:0]          ent_valid,
  output logic [QDEPTH*ADDR_W-1:0]   ent_addr
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [QDEPTH-1:0] vld;
  logic [ADDR_W-1:0] adr [QDEPTH];
  logic [DATA_W-1:0] dat [QDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     head_idx;
  logic [CW-1:0]     lead;
  logic [CW-1:0]     drop;

  // Killed entries ahead of the first live one are discarded in the same cycle it issues.
  always_comb begin
    head_avail = 1'b0;
    head_idx   = rd_ptr;
    lead       = count;
    for (int i = 0; i < QDEPTH; i++) begin
      if (!head_avail && (CW'(i) < count) && vld[rd_ptr + PW'(i)]) begin
        head_avail = 1'b1;
        head_idx   = rd_ptr + PW'(i);
        lead       = CW'(i);
      end
    end
    drop = lead + CW'(pop && head_avail);
  end

  assign head_addr = adr[head_idx];
  assign head_data = dat[head_idx];
  assign ent_valid = vld;

  for (genvar g = 0; g < QDEPTH; g++) begin : g_ent
    assign ent_addr[g*ADDR_W +: ADDR_W] = adr[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (kill_en && (adr[i] == kill_addr)) vld[i] <= 1'b0;
        if (CW'(i) < drop) vld[rd_ptr + PW'(i)] <= 1'b0;
      end
      // The pushed slot is written last so a same-cycle kill never hits the younger entry.
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr + drop[PW-1:0];
      count  <= count + CW'(push) - drop;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      adr[wr_ptr] <= push_addr;
      dat[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and queued other-path results onto the register-file write port
module wb_arbiter import wb_pkg::*; #(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int QDEPTH       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              oth_valid,
  output logic              oth_ready,
  input  logic [ADDR_W-1:0] oth_addr,
  input  logic [DATA_W-1:0] oth_data,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_select,
  output logic [DATA_W-1:0] w_alu,
  output logic [DATA_W-1:0] w_other,
  input  logic [ADDR_W-1:0] r_addr_0,
  input  logic [ADDR_W-1:0] r_addr_1,
  output logic              pend_0,
  output logic              pend_1,
  output logic              alu_hold,
  output logic              wb_err
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                     push;
  logic                     pop;
  logic                     head_avail;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  logic [CW-1:0]            q_count;
  logic [QDEPTH-1:0]        ent_valid;
  logic [QDEPTH*ADDR_W-1:0] ent_addr;
  logic [SW-1:0]            starve_cnt;

  assign oth_ready = (q_count < CW'(QDEPTH));
  assign push      = oth_valid && oth_ready;
  assign pop       = !alu_valid && head_avail;

  wb_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_addr  (oth_addr),
    .push_data  (oth_data),
    .pop        (pop),
    .kill_en    (alu_valid),
    .kill_addr  (alu_addr),
    .head_avail (head_avail),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (q_count),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr)
  );

  always_comb begin
    pend_0 = w_enable && (w_addr == r_addr_0);
    pend_1 = w_enable && (w_addr == r_addr_1);
    for (int i = 0; i < QDEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i*ADDR_W +: ADDR_W] == r_addr_0)) pend_0 = 1'b1;
      if (ent_valid[i] && (ent_addr[i*ADDR_W +: ADDR_W] == r_addr_1)) pend_1 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_enable   <= 1'b0;
      w_addr     <= '0;
      w_select   <= WSEL_ALU;
      w_alu      <= '0;
      w_other    <= '0;
      alu_hold   <= 1'b0;
      wb_err     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (alu_valid) begin
        w_enable <= 1'b1;
        w_addr   <= alu_addr;
        w_select <= WSEL_ALU;
        w_alu    <= alu_data;
      end else if (head_avail) begin
        w_enable <= 1'b1;
        w_addr   <= head_addr;
        w_select <= WSEL_OTHER;
        w_other  <= head_data;
      end else begin
        w_enable <= 1'b0;
      end

      if (alu_valid && alu_hold) wb_err <= 1'b1;

      // Any cycle the head is not pre-empted it either issues or the queue is empty.
      if (alu_valid && head_avail) begin
        if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
          alu_hold   <= 1'b1;
          starve_cnt <= '0;
        end else begin
          alu_hold   <= 1'b0;
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else begin
        alu_hold   <= 1'b0;
        starve_cnt <= '0;
      end
    end
  end

endmodule
